// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register command parser and its register bank.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    localparam int         RW_BIT         = 7;
    localparam logic [7:0] DEV_ID_DEFAULT = 8'hA5;
    localparam logic [7:0] OOR_READ_VAL   = 8'h00;

endpackage

// File: rtl/spi_reg_bank.sv
// Register bank: NUM_REGS x 8 flops, one synchronous write port, one combinational read port.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [7:0]                wr_data,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [7:0]                rd_data,
    output logic [8*(2**ADDR_W)-1:0]  o_Regs
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [7:0] mem_r [NUM_REGS];

    // Bank storage with reset to RESET_VAL and single write port
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign o_Regs[8*g +: 8] = mem_r[g];
    end

endmodule

// File: rtl/spi_reg_cmd_parser.sv
// SPI command layer: decodes cmd/address byte plus data burst, drives the register
// bank with address auto-increment and returns read data to the slave TX path.
module spi_reg_cmd_parser
    import spi_reg_pkg::*;
#(
    parameter int         ADDR_W    = 4,
    parameter logic [7:0] DEV_ID    = DEV_ID_DEFAULT,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_L,
    input  logic                      i_SPI_CS_n,
    input  logic                      i_RX_DV,
    input  logic [7:0]                i_RX_Byte,
    output logic                      o_TX_DV,
    output logic [7:0]                o_TX_Byte,
    output logic                      o_Wr_Strobe,
    output logic [ADDR_W-1:0]         o_Wr_Addr,
    output logic                      o_Addr_Err,
    output logic [8*(2**ADDR_W)-1:0]  o_Regs
);

    logic              cs_meta_r, cs_sync_r, cs_prev_r;
    logic              cs_fall_s, cs_rise_s;
    state_t            state_r, state_s;
    logic [ADDR_W-1:0] addr_r, addr_s, addr_inc_s, cmd_addr_s, rd_addr_s;
    logic [6:0]        cmd_hi_s;
    logic              oor_cmd_s;
    logic              oor_r, oor_s;
    logic              err_r, err_s;
    logic              tx_dv_r, tx_dv_s;
    logic [7:0]        tx_byte_r, tx_byte_s;
    logic              wr_stb_r, wr_en_s;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [7:0]        rd_data_s;

    // CS synchronizer and edge detector; flops reset low so a CS held low across
    // reset never produces a false cs_fall and the interrupted frame stays ignored
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cs_meta_r <= 1'b0;
            cs_sync_r <= 1'b0;
            cs_prev_r <= 1'b0;
        end else begin
            cs_meta_r <= i_SPI_CS_n;
            cs_sync_r <= cs_meta_r;
            cs_prev_r <= cs_sync_r;
        end
    end

    assign cs_fall_s  = cs_prev_r & ~cs_sync_r;
    assign cs_rise_s  = ~cs_prev_r & cs_sync_r;
    assign cmd_addr_s = i_RX_Byte[ADDR_W-1:0];
    assign cmd_hi_s   = i_RX_Byte[6:0] >> ADDR_W;
    assign oor_cmd_s  = (cmd_hi_s != 7'd0);
    assign addr_inc_s = addr_r + ADDR_W'(1'b1);
    assign rd_addr_s  = (state_r == ST_CMD) ? cmd_addr_s : addr_inc_s;

    // FSM state register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; cs_rise overrides everything
    always_comb begin
        state_s = state_r;
        if (cs_rise_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_s = cs_fall_s ? ST_CMD : ST_IDLE;
                ST_CMD: begin
                    if (i_RX_DV) begin
                        state_s = i_RX_Byte[RW_BIT] ? ST_READ : ST_WRITE;
                    end else begin
                        state_s = ST_CMD;
                    end
                end
                ST_WRITE: state_s = ST_WRITE;
                ST_READ:  state_s = ST_READ;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // FSM output logic: next values for TX, write strobe, address and flags
    always_comb begin
        tx_dv_s   = 1'b0;
        tx_byte_s = tx_byte_r;
        wr_en_s   = 1'b0;
        addr_s    = addr_r;
        oor_s     = oor_r;
        err_s     = err_r;
        if (cs_rise_s) begin
            addr_s = addr_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        tx_dv_s   = 1'b1;
                        tx_byte_s = DEV_ID;
                        err_s     = 1'b0;
                        oor_s     = 1'b0;
                    end else begin
                        tx_dv_s = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (i_RX_DV) begin
                        addr_s = cmd_addr_s;
                        oor_s  = oor_cmd_s;
                        err_s  = err_r | oor_cmd_s;
                        if (i_RX_Byte[RW_BIT]) begin
                            tx_dv_s   = 1'b1;
                            tx_byte_s = oor_cmd_s ? OOR_READ_VAL : rd_data_s;
                        end else begin
                            tx_dv_s = 1'b0;
                        end
                    end else begin
                        addr_s = addr_r;
                    end
                end
                ST_WRITE: begin
                    if (i_RX_DV) begin
                        addr_s  = addr_inc_s;
                        wr_en_s = ~oor_r;
                    end else begin
                        addr_s = addr_r;
                    end
                end
                ST_READ: begin
                    if (i_RX_DV) begin
                        addr_s    = addr_inc_s;
                        tx_dv_s   = 1'b1;
                        tx_byte_s = oor_r ? OOR_READ_VAL : rd_data_s;
                    end else begin
                        addr_s = addr_r;
                    end
                end
                default: begin
                    addr_s = addr_r;
                end
            endcase
        end
    end

    // Output and datapath registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tx_dv_r   <= 1'b0;
            tx_byte_r <= 8'h00;
            wr_stb_r  <= 1'b0;
            wr_addr_r <= '0;
            addr_r    <= '0;
            oor_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            tx_dv_r   <= tx_dv_s;
            tx_byte_r <= tx_byte_s;
            wr_stb_r  <= wr_en_s;
            wr_addr_r <= wr_en_s ? addr_r : wr_addr_r;
            addr_r    <= addr_s;
            oor_r     <= oor_s;
            err_r     <= err_s;
        end
    end

    spi_reg_bank #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .wr_en   (wr_en_s),
        .wr_addr (addr_r),
        .wr_data (i_RX_Byte),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s),
        .o_Regs  (o_Regs)
    );

    assign o_TX_DV     = tx_dv_r;
    assign o_TX_Byte   = tx_byte_r;
    assign o_Wr_Strobe = wr_stb_r;
    assign o_Wr_Addr   = wr_addr_r;
    assign o_Addr_Err  = err_r;

endmodule

// File: tb/tb_spi_reg_cmd_parser.sv
// Directed self-checking bench for spi_reg_cmd_parser (ADDR_W=4, DEV_ID=8'hA5).
module tb_spi_reg_cmd_parser;

    logic         i_Clk = 1'b0;
    logic         i_Rst_L;
    logic         i_SPI_CS_n;
    logic         i_RX_DV;
    logic [7:0]   i_RX_Byte;
    logic         o_TX_DV;
    logic [7:0]   o_TX_Byte;
    logic         o_Wr_Strobe;
    logic [3:0]   o_Wr_Addr;
    logic         o_Addr_Err;
    logic [127:0] o_Regs;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int tx_cnt = 0;
    int snap_wr;
    int snap_tx;
    logic [127:0] exp_regs;

    always #5 i_Clk = ~i_Clk;

    spi_reg_cmd_parser #(
        .ADDR_W    (4),
        .DEV_ID    (8'hA5),
        .RESET_VAL (8'h00)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_SPI_CS_n  (i_SPI_CS_n),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .o_Wr_Strobe (o_Wr_Strobe),
        .o_Wr_Addr   (o_Wr_Addr),
        .o_Addr_Err  (o_Addr_Err),
        .o_Regs      (o_Regs)
    );

    // Pulse counters for strobe and TX load events
    always @(posedge i_Clk) begin
        if (o_Wr_Strobe === 1'b1) wr_cnt <= wr_cnt + 1;
        if (o_TX_DV === 1'b1) tx_cnt <= tx_cnt + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One RX byte pulse; returns at the negedge after the capturing posedge
    task automatic send(input logic [7:0] b);
        @(negedge i_Clk);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        @(negedge i_Clk);
        i_RX_DV   = 1'b0;
    endtask

    // Drop CS and land on the cycle where the DEV_ID load pulse is visible
    task automatic cs_drop();
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b0;
        repeat (3) @(negedge i_Clk);
    endtask

    task automatic cs_raise();
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b1;
        repeat (5) @(negedge i_Clk);
    endtask

    initial begin
        i_Rst_L    = 1'b0;
        i_SPI_CS_n = 1'b1;
        i_RX_DV    = 1'b0;
        i_RX_Byte  = 8'h00;
        repeat (3) @(negedge i_Clk);
        check("rst_tx_dv",   128'(o_TX_DV),     128'd0);
        check("rst_tx_byte", 128'(o_TX_Byte),   128'd0);
        check("rst_strobe",  128'(o_Wr_Strobe), 128'd0);
        check("rst_wr_addr", 128'(o_Wr_Addr),   128'd0);
        check("rst_err",     128'(o_Addr_Err),  128'd0);
        check("rst_regs",    o_Regs,            128'd0);
        i_Rst_L = 1'b1;
        repeat (5) @(negedge i_Clk);

        // 1: cs_fall returns DEV_ID as a single pulse
        snap_tx = tx_cnt;
        cs_drop();
        check("t1_tx_dv",   128'(o_TX_DV),   128'd1);
        check("t1_tx_byte", 128'(o_TX_Byte), 128'hA5);
        @(negedge i_Clk);
        check("t1_tx_pulse_end", 128'(o_TX_DV), 128'd0);
        check("t1_tx_count", 128'(tx_cnt - snap_tx), 128'd1);
        check("t1_regs", o_Regs, 128'd0);

        // 2: write 3 <- 11, 4 <- 22
        snap_wr = wr_cnt;
        send(8'h03);
        check("t2_cmd_no_tx",     128'(o_TX_DV),     128'd0);
        check("t2_cmd_no_strobe", 128'(o_Wr_Strobe), 128'd0);
        send(8'h11);
        check("t2_strobe0", 128'(o_Wr_Strobe), 128'd1);
        check("t2_waddr0",  128'(o_Wr_Addr),   128'd3);
        check("t2_reg3",    128'(o_Regs[31:24]), 128'h11);
        send(8'h22);
        check("t2_strobe1", 128'(o_Wr_Strobe), 128'd1);
        check("t2_waddr1",  128'(o_Wr_Addr),   128'd4);
        check("t2_reg4",    128'(o_Regs[39:32]), 128'h22);
        cs_raise();
        check("t2_strobe_count", 128'(wr_cnt - snap_wr), 128'd2);

        // 3: read from 3 with two dummies
        cs_drop();
        send(8'h83);
        check("t3_tx_dv0",   128'(o_TX_DV),   128'd1);
        check("t3_tx_byte0", 128'(o_TX_Byte), 128'h11);
        send(8'h00);
        check("t3_tx_byte1", 128'(o_TX_Byte), 128'h22);
        send(8'h00);
        check("t3_tx_dv2",   128'(o_TX_DV),   128'd1);
        check("t3_tx_byte2", 128'(o_TX_Byte), 128'h00);
        check("t3_err",      128'(o_Addr_Err), 128'd0);
        cs_raise();

        // 4: write 15 <- AA, wrap to 0 <- BB
        cs_drop();
        send(8'h0F);
        send(8'hAA);
        check("t4_waddr15", 128'(o_Wr_Addr), 128'd15);
        check("t4_reg15",   128'(o_Regs[127:120]), 128'hAA);
        send(8'hBB);
        check("t4_waddr_wrap", 128'(o_Wr_Addr), 128'd0);
        check("t4_reg0",       128'(o_Regs[7:0]), 128'hBB);
        cs_raise();
        exp_regs = 128'hAA_00_00_00_00_00_00_00_00_00_00_22_11_00_00_BB;
        check("t4_bank", o_Regs, exp_regs);

        // 5: out-of-range write, sticky error, cleared by next cs_fall
        cs_drop();
        snap_wr = wr_cnt;
        send(8'h40);
        check("t5_err_set", 128'(o_Addr_Err), 128'd1);
        send(8'h55);
        check("t5_no_strobe", 128'(o_Wr_Strobe), 128'd0);
        check("t5_bank_same", o_Regs, exp_regs);
        cs_raise();
        check("t5_strobe_count", 128'(wr_cnt - snap_wr), 128'd0);
        check("t5_err_sticky", 128'(o_Addr_Err), 128'd1);
        cs_drop();
        check("t5_err_cleared", 128'(o_Addr_Err), 128'd0);
        send(8'hC5);
        check("t5_oor_read_dv",   128'(o_TX_DV),    128'd1);
        check("t5_oor_read_byte", 128'(o_TX_Byte),  128'h00);
        check("t5_oor_read_err",  128'(o_Addr_Err), 128'd1);
        cs_raise();

        // 6: cs_rise coincident with RX_DV drops the byte
        cs_drop();
        check("t6_err_cleared", 128'(o_Addr_Err), 128'd0);
        send(8'h07);
        send(8'h77);
        check("t6_reg7", 128'(o_Regs[63:56]), 128'h77);
        i_SPI_CS_n = 1'b1;
        @(negedge i_Clk);
        @(negedge i_Clk);
        i_RX_DV   = 1'b1;
        i_RX_Byte = 8'h99;
        @(negedge i_Clk);
        i_RX_DV   = 1'b0;
        check("t6_drop_no_strobe", 128'(o_Wr_Strobe), 128'd0);
        check("t6_drop_reg8", 128'(o_Regs[71:64]), 128'h00);
        check("t6_state_idle", 128'(dut.state_r), 128'd0);
        repeat (3) @(negedge i_Clk);

        // Reset mid-frame
        cs_drop();
        send(8'h05);
        send(8'h66);
        check("t6_reg5", 128'(o_Regs[47:40]), 128'h66);
        i_Rst_L = 1'b0;
        @(negedge i_Clk);
        check("t6_rst_regs",    o_Regs,            128'd0);
        check("t6_rst_strobe",  128'(o_Wr_Strobe), 128'd0);
        check("t6_rst_wr_addr", 128'(o_Wr_Addr),   128'd0);
        check("t6_rst_tx_byte", 128'(o_TX_Byte),   128'd0);
        check("t6_rst_err",     128'(o_Addr_Err),  128'd0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (4) @(negedge i_Clk);
        snap_wr = wr_cnt;
        snap_tx = tx_cnt;
        send(8'h12);
        send(8'h34);
        check("t6_ignored_regs", o_Regs, 128'd0);
        check("t6_ignored_strobe", 128'(wr_cnt - snap_wr), 128'd0);
        check("t6_ignored_tx", 128'(tx_cnt - snap_tx), 128'd0);
        cs_raise();
        cs_drop();
        check("t6_new_frame_dv",   128'(o_TX_DV),   128'd1);
        check("t6_new_frame_byte", 128'(o_TX_Byte), 128'hA5);
        repeat (4) @(negedge i_Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
